mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
Multicycle signed multiply/divide unit for the MIPS datapath, fed by the A and B operand registers and sequenced by the control FSM.
- Executes MULT and DIV over 32 iteration cycles.
- Holds the 64-bit result in internal HI/LO registers for later MFHI/MFLO write-back through the register-destination/write-data path.
- Control raises `start` in the execute state and stalls on `busy` until `done`.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits. The iteration count equals WIDTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; forces IDLE and clears all registers
- start  input  1  one-cycle request; sampled only in IDLE
- op  input  1  0 = signed MULT, 1 = signed DIV; sampled with start
- a_in  input  WIDTH  operand A (multiplicand / dividend), from the A register output
- b_in  input  WIDTH  operand B (multiplier / divisor), from the B register output
- hi  output  WIDTH  HI register: product[63:32] or remainder
- lo  output  WIDTH  LO register: product[31:0] or quotient
- busy  output  1  high while in MULT or DIV state
- done  output  1  one-cycle pulse; the result is valid in hi/lo
- div_zero  output  1  high with done when the DIV divisor was 0

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state = IDLE; hi = lo = 0; busy = done = div_zero = 0.
  - Iteration counter and internal accumulators cleared.
  - The in-flight operation is discarded.
- States: IDLE, MULT, DIV, DONE. Encoding is free; outputs are registered or decoded from state only.
- IDLE:
  - On the edge E0 with start = 1: latch a_in, b_in and op; counter = 0.
  - Go to MULT (op = 0) or DIV (op = 1, b_in != 0).
  - If op = 1 and b_in = 0: go directly to DONE with div_zero set.
  - start = 0: stay in IDLE.
- MULT (radix-2 Booth, signed two's complement):
  - Edges E1..E32 each perform one iteration.
  - Each iteration examines the pair {Q[0], Q-1}, adds, subtracts or skips the multiplicand into the upper accumulator, then arithmetic-shifts {acc, Q, Q-1} right by 1.
  - At E32: write {hi, lo} = 64-bit signed product; go to DONE.
- DIV (restoring division on magnitudes):
  - Edges E1..E32 each shift {rem, quo} left by 1, trial-subtract |divisor|, and restore if the result is negative.
  - At E32, apply the MIPS sign rules before writing hi/lo:
    - lo = quotient, truncated toward zero; negated if the operand signs differ.
    - hi = remainder, with the sign of the dividend.
  - Then go to DONE.
  - Overflow case 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (natural wrap), with no flag.
- DONE:
  - done = 1 for exactly one cycle; go to IDLE on the next edge.
  - div_zero = 1 in this cycle only for a divide-by-zero request.
  - On divide-by-zero, hi/lo keep their previous values.
- Latency:
  - MULT or nonzero DIV: done is high in the cycle after E32, i.e. 33 cycles after the start edge.
  - Divide by zero: done is high in the cycle after E0.
- busy is high in the MULT and DIV states only. It is low in IDLE and DONE.
- start outside IDLE (including in DONE) is ignored; no queuing.
- Operands are used only in their latched form. Changes on a_in/b_in after E0 have no effect.
- hi/lo hold their value between operations and are updated only at E32 of a completed operation or by reset.

Test Plan:
1. MULT a = 7, b = 0xFFFFFFFD (-3) -> after 33 cycles: done = 1 for 1 cycle; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy high for cycles 1..32.
2. MULT a = 0x80000000, b = 0x80000000 -> hi = 0x40000000, lo = 0x00000000; then MULT 0x0000FFFF * 0x0000FFFF -> hi = 0, lo = 0xFFFE0001.
3. DIV a = 0xFFFFFFF9 (-7), b = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1); DIV a = 7, b = 0xFFFFFFFE -> lo = 0xFFFFFFFD, hi = 1.
4. DIV by zero after a prior result hi = 0x11, lo = 0x22 -> done and div_zero high in the cycle after start, busy never high, hi/lo remain 0x11/0x22.
5. DIV a = 0x80000000, b = 0xFFFFFFFF -> lo = 0x80000000, hi = 0, div_zero = 0.
6. Start MULT, pulse start again and toggle a_in/b_in at cycle 5 -> ignored, original result produced. Start a new MULT and assert reset at cycle 10 -> immediately hi = lo = 0, busy = done = 0, state IDLE; no done pulse follows.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring, magnitudes) unit.
// The 64-bit result is held in HI/LO until the next completed operation.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   m_ext_s;
    logic [WIDTH:0]   booth_sum_s;
    logic [WIDTH:0]   booth_acc_s;
    logic [WIDTH-1:0] booth_q_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_trial_s;
    logic [WIDTH:0]   div_rem_s;
    logic [WIDTH-1:0] div_quo_s;
    logic             last_s;

    function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? neg_val(v) : v;
    endfunction

    // Accumulator is one bit wider so -2^(W-1) multiplicands cannot overflow.
    assign m_ext_s     = {m_q[WIDTH-1], m_q};
    assign booth_acc_s = {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
    assign booth_q_s   = {booth_sum_s[0], q_q[WIDTH-1:1]};
    assign div_shift_s = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign div_trial_s = div_shift_s - {1'b0, m_q};
    assign div_rem_s   = div_trial_s[WIDTH] ? div_shift_s : div_trial_s;
    assign div_quo_s   = {q_q[WIDTH-2:0], ~div_trial_s[WIDTH]};
    assign last_s      = (cnt_q == CW'(WIDTH - 1));

    // Booth add/subtract/skip selection from {Q[0], Q-1}.
    always_comb begin
        booth_sum_s = acc_q;
        case ({q_q[0], qm1_q})
            2'b01:   booth_sum_s = acc_q + m_ext_s;
            2'b10:   booth_sum_s = acc_q - m_ext_s;
            default: booth_sum_s = acc_q;
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;
        case (state_q)
            S_IDLE: begin
                dz_d = 1'b0;
                if (start) begin
                    cnt_d = '0;
                    acc_d = '0;
                    qm1_d = 1'b0;
                    if (!op) begin
                        m_d     = a_in;
                        q_d     = b_in;
                        state_d = S_MULT;
                    end else if (b_in == '0) begin
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        m_d       = abs_val(b_in);
                        q_d       = abs_val(a_in);
                        neg_quo_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        neg_rem_d = a_in[WIDTH-1];
                        state_d   = S_DIV;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MULT: begin
                acc_d = booth_acc_s;
                q_d   = booth_q_s;
                qm1_d = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (last_s) begin
                    hi_d    = booth_acc_s[WIDTH-1:0];
                    lo_d    = booth_q_s;
                    state_d = S_DONE;
                end else begin
                    state_d = S_MULT;
                end
            end
            S_DIV: begin
                acc_d = div_rem_s;
                q_d   = div_quo_s;
                cnt_d = cnt_q + CW'(1);
                if (last_s) begin
                    lo_d    = neg_quo_q ? neg_val(div_quo_s) : div_quo_s;
                    hi_d    = neg_rem_q ? neg_val(div_rem_s[WIDTH-1:0]) : div_rem_s[WIDTH-1:0];
                    state_d = S_DONE;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_DONE: begin
                dz_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dz_q      <= dz_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q == S_MULT) || (state_q == S_DIV);
    assign done     = (state_q == S_DONE);
    assign div_zero = dz_q;

endmodule
